sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO for the sample-streaming datapath. It buffers I/Q samples between the front-end decimation chain and the USB/host packetiser. It generalises the fixed 512x16 FIFO with parametrised width and depth, and uses one exact occupancy counter. It adds a count output, programmable almost-full/almost-empty flags, a read-data valid strobe, and sticky overflow/underflow flags in place of simulation-only checks.

---
 rtl/sync_fifo_param.sv | 100 ++++++++++
 tb/tb_sync_fifo_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO for the sample-streaming datapath, with an exact
// occupancy counter, programmable almost-full/empty flags and sticky error flags.
module sync_fifo_param #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned AFULL_THRESH  = (2**DEPTH_LOG2) - 16,
    parameter int unsigned AEMPTY_THRESH = 16
) (
    input  logic                  fifo_clk,
    input  logic                  reset_,
    input  logic                  fifo_flush,
    input  logic [WIDTH-1:0]      din,
    input  logic                  write_busy,
    input  logic                  read_busy,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned            DEPTH    = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    CNT_FULL = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]    AF_T     = AFULL_THRESH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]    AE_T     = AEMPTY_THRESH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]    CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign fifo_full    = (fifo_count == CNT_FULL);
    assign fifo_empty   = (fifo_count == '0);
    assign almost_full  = (fifo_count >= AF_T);
    assign almost_empty = (fifo_count <= AE_T);

    // Flush masks both accepts so a flushed cycle neither moves data nor sets sticky flags.
    assign wr_acc = write_busy & ~fifo_full  & ~fifo_flush;
    assign rd_acc = read_busy  & ~fifo_empty & ~fifo_flush;

    always_ff @(posedge fifo_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (fifo_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (write_busy && fifo_full) begin
                overflow <= 1'b1;
            end
            if (read_busy && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (rd_acc) begin
            dout       <= mem[rd_ptr];
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a queue-based reference model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_sync_fifo_param;

    logic        fifo_clk = 1'b0;
    logic        reset_;
    logic        fifo_flush;
    logic [15:0] din;
    logic        write_busy;
    logic        read_busy;
    logic [15:0] dout;
    logic        dout_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    sync_fifo_param #(
        .WIDTH(16),
        .DEPTH_LOG2(4),
        .AFULL_THRESH(12),
        .AEMPTY_THRESH(2)
    ) dut (
        .fifo_clk(fifo_clk),
        .reset_(reset_),
        .fifo_flush(fifo_flush),
        .din(din),
        .write_busy(write_busy),
        .read_busy(read_busy),
        .dout(dout),
        .dout_valid(dout_valid),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 fifo_clk = ~fifo_clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Reference model: a queue of stored words plus the registered outputs.
    logic [15:0] m_q[$];
    logic [15:0] m_dout  = '0;
    bit          m_valid = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_unf   = 1'b0;
    bit          m_full, m_empty;

    always @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (fifo_flush) begin
            m_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            m_full  = (m_q.size() == 16);
            m_empty = (m_q.size() == 0);
            if (write_busy && m_full) m_ovf = 1'b1;
            if (read_busy && m_empty) m_unf = 1'b1;
            if (read_busy && !m_empty) begin
                m_dout  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (write_busy && !m_full) m_q.push_back(din);
        end
    end

    always @(negedge fifo_clk) begin
        if (chk_en) begin
            chk("m_dout",         dout,         m_dout);
            chk("m_dout_valid",   dout_valid,   m_valid);
            chk("m_count",        fifo_count,   m_q.size());
            chk("m_full",         fifo_full,    m_q.size() == 16);
            chk("m_empty",        fifo_empty,   m_q.size() == 0);
            chk("m_almost_full",  almost_full,  m_q.size() >= 12);
            chk("m_almost_empty", almost_empty, m_q.size() <= 2);
            chk("m_overflow",     overflow,     m_ovf);
            chk("m_underflow",    underflow,    m_unf);
        end
    end

    task automatic cyc(input logic w, input logic r, input logic f, input logic [15:0] d);
        write_busy = w;
        read_busy  = r;
        fifo_flush = f;
        din        = d;
        @(posedge fifo_clk);
        #1;
        write_busy = 1'b0;
        read_busy  = 1'b0;
        fifo_flush = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"},  fifo_empty,   1);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_count"},  fifo_count,   0);
        chk({tag, "_dout"},   dout,         0);
        chk({tag, "_valid"},  dout_valid,   0);
        chk({tag, "_full"},   fifo_full,    0);
        chk({tag, "_afull"},  almost_full,  0);
        chk({tag, "_ovf"},    overflow,     0);
        chk({tag, "_unf"},    underflow,    0);
    endtask

    initial begin
        reset_     = 1'b0;
        fifo_flush = 1'b0;
        din        = '0;
        write_busy = 1'b0;
        read_busy  = 1'b0;
        repeat (3) @(posedge fifo_clk);
        #1;
        reset_ = 1'b1;
        chk_en = 1'b1;
        chk_reset_vals("rst");
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_reset_vals("idle");

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 0, 16'(i));
            if (i == 11) chk("afull_at11", almost_full, 0);
            if (i == 12) chk("afull_at12", almost_full, 1);
        end
        chk("full_after16", fifo_full, 1);
        cyc(1, 0, 0, 16'hDEAD);
        chk("ovf_count", fifo_count, 16);
        chk("ovf_full",  fifo_full,  1);
        chk("ovf_flag",  overflow,   1);

        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 0);
            chk("drain_data",  dout,       i);
            chk("drain_valid", dout_valid, 1);
        end
        chk("drained_empty", fifo_empty, 1);

        // Read while empty.
        cyc(0, 1, 0, 0);
        chk("unf_flag",  underflow,  1);
        chk("unf_valid", dout_valid, 0);
        chk("unf_dout",  dout,       16'h0010);
        chk("unf_count", fifo_count, 0);

        cyc(0, 0, 1, 0);
        chk("flush_ovf", overflow,  0);
        chk("flush_unf", underflow, 0);

        // Sustained write+read at occupancy 8, wrapping the pointers several times.
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 16'(16'h0100 + i));
        for (int k = 0; k < 40; k++) begin
            cyc(1, 1, 0, 16'(16'h0108 + k));
            chk("stream_count", fifo_count, 8);
            chk("stream_data",  dout,       16'h0100 + k);
            chk("stream_valid", dout_valid, 1);
        end

        // Write+read at full: write rejected.
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 16'(16'h0200 + i));
        chk("full_again", fifo_full, 1);
        cyc(1, 1, 0, 16'hBEEF);
        chk("wr_rd_full_count", fifo_count, 15);
        chk("wr_rd_full_ovf",   overflow,   1);
        chk("wr_rd_full_dout",  dout,       16'h0128);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
        chk("last_word", dout, 16'h0207);
        chk("empty_again", fifo_empty, 1);

        // Write+read at empty: read rejected.
        cyc(1, 1, 0, 16'h0055);
        chk("wr_rd_empty_count", fifo_count, 1);
        chk("wr_rd_empty_unf",   underflow,  1);
        chk("wr_rd_empty_valid", dout_valid, 0);
        cyc(0, 1, 0, 0);
        chk("bypass_free_data", dout, 16'h0055);

        // Flush at count 5 with write and read requested.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'(16'h0300 + i));
        chk("pre_flush_count", fifo_count, 5);
        chk("pre_flush_ovf",   overflow,   1);
        cyc(1, 1, 1, 16'h0777);
        chk("flush_count", fifo_count, 0);
        chk("flush_empty", fifo_empty, 1);
        chk("flush_ovf2",  overflow,   0);
        chk("flush_unf2",  underflow,  0);
        chk("flush_valid", dout_valid, 0);
        chk("flush_dout",  dout,       16'h0055);
        cyc(1, 0, 0, 16'h0A0A);
        cyc(0, 1, 0, 0);
        chk("post_flush_data",  dout,       16'h0A0A);
        chk("post_flush_valid", dout_valid, 1);

        // Asynchronous reset mid-burst at count 7.
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 16'(16'h0400 + i));
        cyc(0, 1, 0, 0);
        chk("pre_rst_count", fifo_count, 7);
        chk("pre_rst_dout",  dout,       16'h0400);
        write_busy = 1'b1;
        din        = 16'h04FF;
        #2;
        reset_ = 1'b0;
        #1;
        chk_reset_vals("midrst");
        write_busy = 1'b0;
        @(posedge fifo_clk);
        @(posedge fifo_clk);
        #1;
        reset_ = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 16'h1234);
        cyc(0, 1, 0, 0);
        chk("post_rst_data",  dout,       16'h1234);
        chk("post_rst_valid", dout_valid, 1);
        cyc(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
